// File: rtl/tetris_pkg.sv
// tetris_pkg: shared state encodings, move codes and board geometry for the tetris sequencer.
package tetris_pkg;
   localparam int BOARD_W = 32;
   localparam logic [4:0] SPAWN_LOC = 5'd2;
   typedef enum logic [2:0] {
      S_GEN      = 3'd0,
      S_MOVE     = 3'd1,
      S_LAND     = 3'd2,
      S_CLEAR    = 3'd3,
      S_NEWBOARD = 3'd4,
      S_GAMEOVER = 3'd5
   } state_t;
   typedef enum logic [1:0] {
      MV_DROP   = 2'd0,
      MV_LEFT   = 2'd1,
      MV_RIGHT  = 2'd2,
      MV_ROTATE = 2'd3
   } move_t;
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player move handshake between input debounce (master) and game_ctrl (slave).
interface game_ctrl_if;
   logic       move_valid;
   logic [1:0] move_code;
   logic       move_ready;
   modport master (output move_valid, move_code, input move_ready);
   modport slave  (input move_valid, move_code, output move_ready);
endinterface

// File: rtl/game_ctrl_drop_timer.sv
// drop_timer: gravity counter that ticks every DROP_PERIOD enabled cycles; clr restarts the period.
module drop_timer #(
   parameter int DROP_PERIOD = 8
) (
   input  logic clka,
   input  logic restart,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CW = (DROP_PERIOD > 2) ? $clog2(DROP_PERIOD) : 1;
   logic [CW-1:0] cnt;
   assign tick = en && cnt == CW'(DROP_PERIOD - 1);
   always_ff @(posedge clka or negedge restart) begin
      if (!restart) cnt <= '0;
      else if (clr || tick) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: tetris game sequencer; serialises player moves and gravity into single-cycle dp steps.
// Optional SCORE_EN adds a saturating pieces_landed counter.
module game_ctrl
   import tetris_pkg::*;
#(
   parameter int DROP_PERIOD = 8,
   parameter int SCORE_W     = 8
) (
   input  logic                 clka,
   input  logic                 restart,
   input  logic                 start,
   game_ctrl_if.slave           ctrl,
   output logic [2:0]           state,
   output logic [1:0]           move,
   output logic [BOARD_W-1:0]   board_in,
   output logic [4:0]           location_in,
   output logic [1:0]           rotation_in,
   output logic [1:0]           curr_piece_in,
   input  logic [BOARD_W-1:0]   dp_board_out,
   input  logic [4:0]           dp_location_out,
   input  logic [1:0]           dp_rotation_out,
   input  logic [1:0]           dp_curr_piece_out,
   input  logic                 dp_touched,
   input  logic                 dp_error,
   output logic                 game_over
`ifdef SCORE_EN
   ,output logic [SCORE_W-1:0]  pieces_landed
`endif
);
   if (DROP_PERIOD < 2 || SCORE_W < 1) begin : g_bad_param
      $error("game_ctrl: DROP_PERIOD must be >= 2 and SCORE_W >= 1");
   end
   state_t st;
   logic   in_move, tick, accept, step, drop, land;
   assign state     = st;
   assign game_over = st == S_GAMEOVER;
   assign in_move   = st == S_MOVE;
   // gravity wins a collision with a player move; the move stays pending
   assign ctrl.move_ready = in_move && !tick;
   assign accept = ctrl.move_valid && ctrl.move_ready;
   assign step   = tick || accept;
   assign move   = accept ? ctrl.move_code : 2'd0;
   assign drop   = step && move == MV_DROP;
   assign land   = drop && dp_touched;
   drop_timer #(.DROP_PERIOD(DROP_PERIOD)) u_timer (
      .clka    (clka),
      .restart (restart),
      .en      (in_move),
      .clr     (st == S_GEN || drop),
      .tick    (tick)
   );
   always_ff @(posedge clka or negedge restart) begin
      if (!restart) begin
         st            <= S_NEWBOARD;
         board_in      <= '0;
         location_in   <= '0;
         rotation_in   <= '0;
         curr_piece_in <= '0;
      end else begin
         case (st)
            S_NEWBOARD: begin
               board_in      <= '0;
               location_in   <= SPAWN_LOC;
               rotation_in   <= '0;
               curr_piece_in <= '0;
               st            <= S_GEN;
            end
            S_GEN: begin
               curr_piece_in <= dp_curr_piece_out;
               location_in   <= SPAWN_LOC;
               rotation_in   <= '0;
               st            <= |board_in[BOARD_W-1 -: 4] ? S_GAMEOVER : S_MOVE;
            end
            S_MOVE: begin
               // a landing drop leaves the piece where it was before the step
               if (land) st <= S_LAND;
               else if (step) begin
                  location_in <= dp_location_out;
                  rotation_in <= dp_rotation_out;
               end
            end
            S_LAND: begin
               board_in <= dp_board_out;
               st       <= S_CLEAR;
            end
            S_CLEAR: begin
               board_in <= dp_board_out;
               st       <= dp_error ? S_GAMEOVER : S_GEN;
            end
            S_GAMEOVER: if (start) st <= S_NEWBOARD;
            default: st <= S_NEWBOARD;
         endcase
      end
   end
`ifdef SCORE_EN
   always_ff @(posedge clka or negedge restart) begin
      if (!restart) pieces_landed <= '0;
      else if (st == S_NEWBOARD) pieces_landed <= '0;
      else if (land && !(&pieces_landed)) pieces_landed <= pieces_landed + 1'b1;
   end
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized scoreboard bench for game_ctrl against a rule-level game model.
module tb_game_ctrl;
   localparam int DP = 8;
   localparam int SW = 8;
   localparam int SC_MAX = (1 << SW) - 1;
   logic        clka = 1'b0;
   logic        restart = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  state;
   logic [1:0]  move;
   logic [31:0] board_in;
   logic [4:0]  location_in;
   logic [1:0]  rotation_in, curr_piece_in;
   logic [31:0] dp_board_out = '0;
   logic [4:0]  dp_location_out = '0;
   logic [1:0]  dp_rotation_out = '0, dp_curr_piece_out = '0;
   logic        dp_touched = 1'b0, dp_error = 1'b0;
   logic        game_over;
`ifdef SCORE_EN
   logic [SW-1:0] pieces_landed;
`endif
   game_ctrl_if ctrl_bus ();
   game_ctrl #(.DROP_PERIOD(DP), .SCORE_W(SW)) dut (
      .clka              (clka),
      .restart           (restart),
      .start             (start),
      .ctrl              (ctrl_bus),
      .state             (state),
      .move              (move),
      .board_in          (board_in),
      .location_in       (location_in),
      .rotation_in       (rotation_in),
      .curr_piece_in     (curr_piece_in),
      .dp_board_out      (dp_board_out),
      .dp_location_out   (dp_location_out),
      .dp_rotation_out   (dp_rotation_out),
      .dp_curr_piece_out (dp_curr_piece_out),
      .dp_touched        (dp_touched),
      .dp_error          (dp_error),
      .game_over         (game_over)
`ifdef SCORE_EN
      ,.pieces_landed    (pieces_landed)
`endif
   );
   always #5 clka = ~clka;
   typedef struct packed {
      logic [2:0]    st;
      logic [1:0]    mv;
      logic          rdy;
      logic [31:0]   brd;
      logic [4:0]    loc;
      logic [1:0]    rot;
      logic [1:0]    pc;
      logic          go;
      logic [SW-1:0] sc;
   } obs_t;
   obs_t exp_q[$];
   int checks = 0;
   int errors = 0;
   // game model: phase names follow the published state numbers
   int          m_st = 4;
   logic [31:0] m_brd = '0;
   logic [4:0]  m_loc = '0;
   logic [1:0]  m_rot = '0, m_pc = '0;
   int          m_since_drop = 0;
   int          m_sc = 0;
   int          density = 50;
   task automatic model_reset();
      m_st = 4; m_brd = '0; m_loc = '0; m_rot = '0; m_pc = '0; m_since_drop = 0; m_sc = 0;
   endtask
   task automatic cycle(input bit hold_reset);
      obs_t e;
      bit gravity, accepted, dropped;
      logic [1:0] step_code;
      @(negedge clka);
      #1;
      restart = !hold_reset;
      ctrl_bus.move_valid = $urandom_range(0, 99) < density;
      ctrl_bus.move_code  = 2'($urandom_range(0, 3));
      dp_touched          = $urandom_range(0, 7) == 0;
      dp_error            = $urandom_range(0, 3) == 0;
      start               = $urandom_range(0, 2) == 0;
      dp_board_out        = ($urandom_range(0, 5) == 0) ? 32'($urandom) : {4'h0, 28'($urandom)};
      dp_location_out     = 5'($urandom);
      dp_rotation_out     = 2'($urandom);
      dp_curr_piece_out   = 2'($urandom);
      if (hold_reset) model_reset();
      gravity   = m_st == 1 && m_since_drop == DP - 1;
      accepted  = m_st == 1 && !gravity && ctrl_bus.move_valid;
      step_code = accepted ? ctrl_bus.move_code : 2'd0;
      dropped   = (gravity || accepted) && step_code == 2'd0;
      e.st  = 3'(m_st);
      e.mv  = step_code;
      e.rdy = m_st == 1 && !gravity;
      e.brd = m_brd;
      e.loc = m_loc;
      e.rot = m_rot;
      e.pc  = m_pc;
      e.go  = m_st == 5;
`ifdef SCORE_EN
      e.sc  = SW'(m_sc);
`else
      e.sc  = '0;
`endif
      exp_q.push_back(e);
      if (!hold_reset) begin
         case (m_st)
            4: begin m_brd = '0; m_loc = 5'd2; m_rot = '0; m_pc = '0; m_sc = 0; m_st = 0; end
            0: begin
               m_pc = dp_curr_piece_out; m_loc = 5'd2; m_rot = '0; m_since_drop = 0;
               m_st = (m_brd[31:28] != 4'h0) ? 5 : 1;
            end
            1: begin
               if (dropped && dp_touched) begin
                  m_st = 2;
                  if (m_sc < SC_MAX) m_sc++;
               end else if (gravity || accepted) begin
                  m_loc = dp_location_out; m_rot = dp_rotation_out;
               end
               m_since_drop = dropped ? 0 : m_since_drop + 1;
            end
            2: begin m_brd = dp_board_out; m_st = 3; end
            3: begin m_brd = dp_board_out; m_st = dp_error ? 5 : 0; end
            default: if (start) m_st = 4;
         endcase
      end
   endtask
   initial begin : monitor
      obs_t e, a;
      int n = 0;
      forever begin
         @(negedge clka);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.st  = state;
            a.mv  = move;
            a.rdy = ctrl_bus.move_ready;
            a.brd = board_in;
            a.loc = location_in;
            a.rot = rotation_in;
            a.pc  = curr_piece_in;
            a.go  = game_over;
`ifdef SCORE_EN
            a.sc  = pieces_landed;
`else
            a.sc  = '0;
`endif
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL obs%0d got st=%0d mv=%0d rdy=%0b brd=%h loc=%0d rot=%0d pc=%0d go=%0b sc=%0d expected st=%0d mv=%0d rdy=%0b brd=%h loc=%0d rot=%0d pc=%0d go=%0b sc=%0d",
                        n, a.st, a.mv, a.rdy, a.brd, a.loc, a.rot, a.pc, a.go, a.sc,
                        e.st, e.mv, e.rdy, e.brd, e.loc, e.rot, e.pc, e.go, e.sc);
            end
            n++;
         end
      end
   end
   initial begin : driver
      ctrl_bus.move_valid = 1'b0;
      ctrl_bus.move_code  = 2'd0;
      repeat (2) cycle(1'b1);
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) density = (i / 250) % 4 == 0 ? 0 : (i / 250) % 4 == 1 ? 25 : (i / 250) % 4 == 2 ? 70 : 100;
         cycle(i == 1777 || $urandom_range(0, 399) == 0);
      end
      repeat (3) @(negedge clka);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
